// File: rtl/test0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test0_pkg
// Description : Shared types, widths and value functions for the conv harness.
// Revision    : 1.0
// ============================================================================
package test0_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] pix(input int r, input int c, input int d);
    return 8'(r + c + d);
  endfunction

  function automatic logic [63:0] exp_result(input int k, input int i, input int j,
                                             input int kk, input int depth);
    logic [63:0] area;
    area = 64'(kk * kk * depth);
    return 64'(k + 1) * (area * 64'(i + j + kk - 1) + area * 64'(depth - 1) / 64'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/test0_if.sv
`default_nettype none
// ============================================================================
// Module      : test0_if
// Description : Control and result bus of the conv harness; err exists only
//               when SELF_CHECK_EN is defined.
// Revision    : 1.0
// ============================================================================
interface test0_if
  import test0_pkg::*;
#(
  parameter int ROWS        = 20,
  parameter int COLS        = 20,
  parameter int NUM_KERNELS = 1,
  parameter int ACC_W       = ACC_W_DEF
);
  localparam int c_row_w = cw(ROWS);
  localparam int c_col_w = cw(COLS);

  logic                         start;
  logic                         busy;
  logic                         out_valid;
  logic [c_row_w-1:0]           out_row;
  logic [c_col_w-1:0]           out_col;
  logic [NUM_KERNELS*ACC_W-1:0] out_data;
  logic [ACC_W-1:0]             checksum;
  logic                         done;
`ifdef SELF_CHECK_EN
  logic                         err;
`endif

  modport master (
    input  start,
    output busy, out_valid, out_row, out_col, out_data, checksum,
`ifdef SELF_CHECK_EN
    output err,
`endif
    output done
  );

  modport slave (
    output start,
    input  busy, out_valid, out_row, out_col, out_data, checksum,
`ifdef SELF_CHECK_EN
    input  err,
`endif
    input  done
  );

endinterface
`default_nettype wire

// File: rtl/test0_wrapper_window_sum.sv
`default_nettype none
// ============================================================================
// Module      : window_sum
// Description : K-1 line buffers plus KxK column-sum window over a depth-sum
//               stream; emits tagged box sums one cycle after the input.
// Revision    : 1.0
// ============================================================================
module window_sum
  import test0_pkg::*;
#(
  parameter int COLS  = 20,
  parameter int K     = 3,
  parameter int ACC_W = ACC_W_DEF,
  parameter int ROW_W = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_clr,
  input  wire logic                  i_valid,
  input  wire logic [ACC_W-1:0]      i_sum,
  output logic                       o_valid,
  output logic [ROW_W-1:0]           o_row,
  output logic [cw(COLS)-1:0]        o_col,
  output logic [ACC_W-1:0]           o_sum
);
  localparam int c_col_w = cw(COLS);
  localparam int c_lb_n  = (K > 1) ? K - 1 : 1;
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(COLS - 1);
  localparam logic [c_col_w-1:0] c_k1_col   = c_col_w'(K - 1);
  localparam logic [ROW_W-1:0]   c_k1_row   = ROW_W'(K - 1);

  logic [c_lb_n-1:0][COLS-1:0][ACC_W-1:0] r_lb;
  logic [c_lb_n-1:0][ACC_W-1:0]           r_win;
  logic [c_col_w-1:0]                     r_col;
  logic [ROW_W-1:0]                       r_row;
  logic [ACC_W-1:0]                       w_colsum;
  logic [ACC_W-1:0]                       w_box;
  logic                                   w_in_win;

  // Column sum spans rows r-K+1..r; the box adds the K-1 previous column sums.
  always_comb begin
    w_colsum = i_sum;
    for (int m = 0; m < K - 1; m++) w_colsum = w_colsum + r_lb[m][r_col];
    w_box = w_colsum;
    for (int m = 0; m < K - 1; m++) w_box = w_box + r_win[m];
  end

  assign w_in_win = (r_row >= c_k1_row) && (r_col >= c_k1_col);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lb    <= '0;
      r_win   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      o_valid <= 1'b0;
      o_row   <= '0;
      o_col   <= '0;
      o_sum   <= '0;
    end else if (i_clr) begin
      r_col   <= '0;
      r_row   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid && w_in_win;
      if (i_valid) begin
        if (K > 1) begin
          r_lb[0][r_col] <= i_sum;
          r_win[0]       <= w_colsum;
        end
        for (int m = 1; m < K - 1; m++) begin
          r_lb[m][r_col] <= r_lb[m-1][r_col];
          r_win[m]       <= r_win[m-1];
        end
        if (r_col == c_col_last) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_in_win) begin
          o_row <= r_row - c_k1_row;
          o_col <= r_col - c_k1_col;
          o_sum <= w_box;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/test0_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : test0_wrapper
// Description : Self-contained conv test harness: pixel generator, depth
//               accumulator, window sum, kernel scaling and checksum.
//               Optional SELF_CHECK_EN adds a closed-form comparator (err).
// Revision    : 1.0
// ============================================================================
module test0_wrapper
  import test0_pkg::*;
#(
  parameter int ROWS        = 20,
  parameter int COLS        = 20,
  parameter int DEPTH       = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 1,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  wire logic clk_100MHz,
  input  wire logic rst,
  test0_if.master   bus
);
  localparam int c_row_w = cw(ROWS);
  localparam int c_col_w = cw(COLS);
  localparam int c_dep_w = cw(DEPTH);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROWS - 1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(COLS - 1);
  localparam logic [c_dep_w-1:0] c_dep_last = c_dep_w'(DEPTH - 1);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_drain;
  logic [c_row_w-1:0]           r_gr;
  logic [c_col_w-1:0]           r_gc;
  logic [c_dep_w-1:0]           r_gd;
  logic [ACC_W-1:0]             r_acc;
  logic                         r_out_valid;
  logic [c_row_w-1:0]           r_out_row;
  logic [c_col_w-1:0]           r_out_col;
  logic [NUM_KERNELS*ACC_W-1:0] r_out_data;
  logic [ACC_W-1:0]             r_chk;
  logic                         r_done;

  logic                         w_accept;
  logic                         w_gen_valid;
  logic                         w_last_elem;
  logic                         w_s_valid;
  logic [7:0]                   w_pix;
  logic [ACC_W-1:0]             w_s;
  logic                         w_win_valid;
  logic [c_row_w-1:0]           w_win_row;
  logic [c_col_w-1:0]           w_win_col;
  logic [ACC_W-1:0]             w_win_sum;
  logic [NUM_KERNELS*ACC_W-1:0] w_data;

  assign w_accept    = bus.start && (r_state == ST_IDLE);
  assign w_gen_valid = (r_state == ST_RUN);
  assign w_last_elem = (r_gr == c_row_last) && (r_gc == c_col_last) && (r_gd == c_dep_last);
  assign w_pix       = pix(int'(r_gr), int'(r_gc), int'(r_gd));
  assign w_s         = r_acc + ACC_W'(w_pix);
  assign w_s_valid   = w_gen_valid && (r_gd == c_dep_last);

  always_ff @(posedge clk_100MHz) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == ST_DRAIN);
    end
  end

  // Two drain cycles cover the depth-sum and window pipeline stages.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)    w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last_elem) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain)     w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  window_sum #(
    .COLS  (COLS),
    .K     (KERNEL_SIZE),
    .ACC_W (ACC_W),
    .ROW_W (c_row_w)
  ) u_window_sum (
    .clk     (clk_100MHz),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_valid (w_s_valid),
    .i_sum   (w_s),
    .o_valid (w_win_valid),
    .o_row   (w_win_row),
    .o_col   (w_win_col),
    .o_sum   (w_win_sum)
  );

  for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_lane
    assign w_data[k*ACC_W +: ACC_W] = w_win_sum * ACC_W'(k + 1);
  end

`ifdef SELF_CHECK_EN
  logic                   r_err;
  logic [NUM_KERNELS-1:0] w_mis_vec;

  for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_cmp
    assign w_mis_vec[k] = (w_data[k*ACC_W +: ACC_W] !=
                           ACC_W'(exp_result(k, int'(w_win_row), int'(w_win_col),
                                             KERNEL_SIZE, DEPTH)));
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst || w_accept) r_err <= 1'b0;
    else if (w_win_valid && (|w_mis_vec)) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (!rst || w_accept) begin
      r_gr        <= '0;
      r_gc        <= '0;
      r_gd        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_data  <= '0;
      r_chk       <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_gen_valid) begin
        if (r_gd == c_dep_last) begin
          r_gd  <= '0;
          r_acc <= '0;
          if (r_gc == c_col_last) begin
            r_gc <= '0;
            r_gr <= r_gr + 1'b1;
          end else begin
            r_gc <= r_gc + 1'b1;
          end
        end else begin
          r_gd  <= r_gd + 1'b1;
          r_acc <= w_s;
        end
      end
      r_out_valid <= w_win_valid;
      if (w_win_valid) begin
        r_out_row  <= w_win_row;
        r_out_col  <= w_win_col;
        r_out_data <= w_data;
        r_chk      <= r_chk + w_win_sum;
      end
      if ((r_state == ST_DRAIN) && r_drain) r_done <= 1'b1;
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.out_data  = r_out_data;
  assign bus.checksum  = r_chk;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_test0_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_test0_wrapper
// Description : Directed bench for the conv harness (default and 2-kernel DUTs).
// Revision    : 1.0
// ============================================================================
module tb_test0_wrapper;
  localparam int ROWS  = 20;
  localparam int COLS  = 20;
  localparam int DEPTH = 8;
  localparam int K     = 3;
  localparam int ACC_W = 32;
  localparam int OUT_R = ROWS - K + 1;
  localparam int OUT_C = COLS - K + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  test0_if #(.ROWS(ROWS), .COLS(COLS), .NUM_KERNELS(1), .ACC_W(ACC_W)) bus ();
  test0_if #(.ROWS(ROWS), .COLS(COLS), .NUM_KERNELS(2), .ACC_W(ACC_W)) bus2 ();

  test0_wrapper #(
    .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .KERNEL_SIZE(K),
    .NUM_KERNELS(1), .ACC_W(ACC_W)
  ) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  test0_wrapper #(
    .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .KERNEL_SIZE(K),
    .NUM_KERNELS(2), .ACC_W(ACC_W)
  ) dut2 (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Brute-force box sum straight from the pixel definition.
  function automatic logic [31:0] box(input int i, input int j);
    int s;
    s = 0;
    for (int r = i; r < i + K; r++)
      for (int c = j; c < j + K; c++)
        for (int d = 0; d < DEPTH; d++)
          s += (r + c + d) % 256;
    return 32'(s);
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},     bus.busy,      0);
    check({tag, "_valid"},    bus.out_valid, 0);
    check({tag, "_row"},      bus.out_row,   0);
    check({tag, "_col"},      bus.out_col,   0);
    check({tag, "_data"},     bus.out_data,  0);
    check({tag, "_checksum"}, bus.checksum,  0);
    check({tag, "_done"},     bus.done,      0);
    check({tag, "_done2"},    bus2.done,     0);
`ifdef SELF_CHECK_EN
    check({tag, "_err"},      bus.err,       0);
`endif
  endtask

  task automatic do_run(input int abort_cyc, input bit poke_busy);
    int          ei, ej, n_strb, done_cyc;
    logic [31:0] w, run_sum;
    ei = 0; ej = 0; n_strb = 0; done_cyc = -1; run_sum = '0;
    bus.start  = 1'b1;
    bus2.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    check("busy_after_start", bus.busy,     1);
    check("start_clr_chk",    bus.checksum, 0);
    check("start_clr_done",   bus.done,     0);
    check("start_clr_row",    bus.out_row,  0);
    check("start_clr_col",    bus.out_col,  0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle_zero("abort");
        return;
      end
      if (bus.out_valid) begin
        w = box(ei, ej);
        run_sum = run_sum + w;
        if (n_strb == 0) begin
          check("first_cycle", cyc, 345);
          check("first_396", bus.out_data, 396);
          check("first_k1_792", bus2.out_data[63:32], 792);
        end
        if (n_strb == 1) check("second_468", bus.out_data, 468);
        check("row",      bus.out_row,  ei);
        check("col",      bus.out_col,  ej);
        check("data",     bus.out_data, w);
        check("checksum", bus.checksum, run_sum);
        check("k2_valid", bus2.out_valid, 1);
        check("k2_lane0", bus2.out_data[31:0],  w);
        check("k2_lane1", bus2.out_data[63:32], 2 * w);
        n_strb++;
        if (ej == OUT_C - 1) begin
          ej = 0;
          ei++;
        end else begin
          ej++;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      bus.start = poke_busy && (cyc == 500);
      tick();
    end
    bus.start = 1'b0;
    check("done_seen",     done_cyc >= 0, 1);
    check("done_latency",  done_cyc, 3202);
    check("strobes",       n_strb, OUT_R * OUT_C);
    check("final_chk",     bus.checksum, 524880);
    check("final_chk2",    bus2.checksum, 524880);
    check("busy_at_done",  bus.busy, 0);
    check("done2",         bus2.done, 1);
    check("last_row_held", bus.out_row, 17);
    check("last_col_held", bus.out_col, 17);
    check("last_2844",     bus.out_data, 2844);
`ifdef SELF_CHECK_EN
    check("err_clean",     bus.err, 0);
    check("err2_clean",    bus2.err, 0);
`endif
  endtask

  initial begin
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    rst        = 1'b0;
    repeat (10) tick();
    check_idle_zero("reset");
    rst = 1'b1;
    repeat (5) tick();
    check_idle_zero("no_start");

    do_run(0, 1'b1);
    repeat (3) tick();
    check("done_held",      bus.done, 1);
    check("busy_low_held",  bus.busy, 0);
    check("valid_low_held", bus.out_valid, 0);

    do_run(1000, 1'b0);
    repeat (2) tick();
    check("abort_no_done", bus.done, 0);

    do_run(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
